// File: rtl/sb_tx_pkg.sv
// Shared types and default sizes for the sideband TX serializer.
package sb_tx_pkg;

    localparam int unsigned SB_PKT_W  = 64;
    localparam int unsigned SB_GAP_UI = 32;
    localparam int unsigned SB_DEPTH  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } sb_tx_state_e;

endpackage

// File: rtl/sb_tx_fifo.sv
// Synchronous word FIFO feeding the serializer; full/empty and read data are registered.
module sb_tx_fifo
    import sb_tx_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH,
    parameter int unsigned PKT_W = SB_PKT_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [PKT_W-1:0] wdata_i,
    input  logic             pop_i,
    output logic [PKT_W-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PKT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic [PKT_W-1:0] rdata_q;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push_i && !full_q;
    assign pop_ok  = pop_i && !empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push_ok && !pop_ok)      cnt_d = cnt_q + CNT_W'(1);
        else if (pop_ok && !push_ok) cnt_d = cnt_q - CNT_W'(1);
        full_d  = (cnt_d == CNT_W'(DEPTH));
        empty_d = (cnt_d == '0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            rdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            if (pop_ok) rdata_q <= mem[rd_ptr_q];
        end
    end

    // Storage array carries no reset; only written entries are ever read.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = rdata_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/sb_tx_serializer.sv
// Sideband TX serializer: buffers words, shifts them out LSB-first with a gated clock and idle gap.
// Optional sticky drop flag enabled by SB_TX_OVERFLOW_STATUS_EN.
module sb_tx_serializer
    import sb_tx_pkg::*;
#(
    parameter int unsigned DEPTH  = SB_DEPTH,
    parameter int unsigned PKT_W  = SB_PKT_W,
    parameter int unsigned GAP_UI = SB_GAP_UI
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_write_enable,
    input  logic [PKT_W-1:0] i_data_in,
`ifdef SB_TX_OVERFLOW_STATUS_EN
    input  logic             i_overflow_clr,
    output logic             o_overflow,
`endif
    output logic             o_fifo_full,
    output logic             o_fifo_empty,
    output logic             o_txdatasb,
    output logic             o_txcksb_en,
    output logic             o_ser_done,
    output logic             o_busy
);

    localparam int unsigned BIT_W = $clog2(PKT_W);
    localparam int unsigned GAP_W = $clog2(GAP_UI + 1);

    sb_tx_state_e     state_q, state_d;
    logic [PKT_W-1:0] shreg_q, shreg_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             txd_q, txd_d;
    logic             cken_q, cken_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             pop_c;
    logic [PKT_W-1:0] fifo_rdata;

    sb_tx_fifo #(
        .DEPTH (DEPTH),
        .PKT_W (PKT_W)
    ) u_fifo (
        .clk_i   (i_clk),
        .rst_ni  (i_rst_n),
        .push_i  (i_write_enable),
        .wdata_i (i_data_in),
        .pop_i   (pop_c),
        .rdata_o (fifo_rdata),
        .full_o  (o_fifo_full),
        .empty_o (o_fifo_empty)
    );

    // Output registers hold what the lane shows next cycle, so LOAD primes bit 0.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        txd_d     = 1'b0;
        cken_d    = 1'b0;
        done_d    = 1'b0;
        pop_c     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!o_fifo_empty) begin
                    pop_c   = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                shreg_d   = fifo_rdata;
                bit_cnt_d = '0;
                txd_d     = fifo_rdata[0];
                cken_d    = 1'b1;
                done_d    = (PKT_W == 1);
                state_d   = SHIFT;
            end
            SHIFT: begin
                if (bit_cnt_q == BIT_W'(PKT_W - 1)) begin
                    gap_cnt_d = '0;
                    state_d   = GAP;
                end else begin
                    shreg_d   = shreg_q >> 1;
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    txd_d     = shreg_q[1];
                    cken_d    = 1'b1;
                    done_d    = (bit_cnt_q == BIT_W'(PKT_W - 2));
                end
            end
            GAP: begin
                gap_cnt_d = gap_cnt_q + GAP_W'(1);
                if (gap_cnt_q == GAP_W'(GAP_UI - 1)) begin
                    if (!o_fifo_empty) begin
                        pop_c   = 1'b1;
                        state_d = LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            txd_q     <= 1'b0;
            cken_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            txd_q     <= txd_d;
            cken_q    <= cken_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

`ifdef SB_TX_OVERFLOW_STATUS_EN
    logic ovf_q;

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ovf_q <= 1'b0;
        end else if (i_write_enable && o_fifo_full) begin
            ovf_q <= 1'b1;
        end else if (i_overflow_clr) begin
            ovf_q <= 1'b0;
        end
    end

    assign o_overflow = ovf_q;
`endif

    assign o_txdatasb  = txd_q;
    assign o_txcksb_en = cken_q;
    assign o_ser_done  = done_q;
    assign o_busy      = busy_q;

endmodule

// File: tb/tb_sb_tx_serializer.sv
// Scoreboard bench for sb_tx_serializer: queue-based service model predicts pops and burst timing.
module tb_sb_tx_serializer;

    localparam int PW   = 64;
    localparam int GAP  = 32;
    localparam int DEP  = 4;
    localparam int SPAN = 1 + PW + GAP;

    typedef struct {
        logic [63:0] w;
        int          first;
    } exp_t;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_write_enable = 1'b0;
    logic [63:0] i_data_in = '0;
    logic        o_fifo_full, o_fifo_empty, o_txdatasb, o_txcksb_en, o_ser_done, o_busy;

    sb_tx_serializer dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_write_enable (i_write_enable),
        .i_data_in      (i_data_in),
        .o_fifo_full    (o_fifo_full),
        .o_fifo_empty   (o_fifo_empty),
        .o_txdatasb     (o_txdatasb),
        .o_txcksb_en    (o_txcksb_en),
        .o_ser_done     (o_ser_done),
        .o_busy         (o_busy)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc++;

    int tests = 0;
    int fails = 0;

    logic [63:0] mq[$];
    exp_t        sb[$];
    int          last_pop = 0;
    bit          has_pop = 1'b0;
    int          exp_pkts = 0;
    int          done_cnt = 0;
    int          drops = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic checkw(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic checki(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One cycle: compare flags with the model, advance the model, drive inputs.
    task automatic step(input bit w, input logic [63:0] d);
        int   n;
        bit   busy_exp;
        exp_t e;
        n        = mq.size();
        busy_exp = has_pop && ((cyc - last_pop) <= SPAN);
        check1("fifo_full", o_fifo_full, n == DEP);
        check1("fifo_empty", o_fifo_empty, n == 0);
        check1("busy", o_busy, busy_exp);
        if (n > 0 && (!has_pop || cyc >= last_pop + SPAN)) begin
            e.w     = mq.pop_front();
            e.first = cyc + 2;
            sb.push_back(e);
            last_pop = cyc;
            has_pop  = 1'b1;
            exp_pkts++;
        end
        if (w && n < DEP) mq.push_back(d);
        else if (w)       drops++;
        i_write_enable = w;
        i_data_in      = d;
        @(negedge i_clk);
    endtask

    task automatic idle(input int k);
        repeat (k) step(1'b0, '0);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Monitor: rebuild each burst and compare it with the scoreboard head.
    int          nbits = 0;
    logic [63:0] acc = '0;
    logic [63:0] dvec = '0;
    exp_t        cur;
    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            nbits = 0;
        end else if (o_txcksb_en) begin
            if (nbits == 0) begin
                if (sb.size() > 0) cur = sb[0];
                else begin
                    cur.w     = '0;
                    cur.first = -1;
                end
                checki("first_bit_cycle", cyc, cur.first);
            end
            acc[nbits]  = o_txdatasb;
            dvec[nbits] = o_ser_done;
            if (o_ser_done) done_cnt++;
            nbits++;
            if (nbits == PW) begin
                checkw("word", acc, cur.w);
                checkw("done_position", dvec, 64'h8000_0000_0000_0000);
                if (sb.size() > 0) void'(sb.pop_front());
                nbits = 0;
            end
        end else begin
            if (nbits != 0) checki("burst_length", nbits, PW);
            nbits = 0;
            check1("gated_lane_low", o_txdatasb | o_ser_done, 1'b0);
        end
    end

    initial begin
        int k;
        int target;
        i_rst_n = 1'b0;
        repeat (3) @(negedge i_clk);
        check1("rst_txdatasb", o_txdatasb, 1'b0);
        check1("rst_txcksb_en", o_txcksb_en, 1'b0);
        check1("rst_ser_done", o_ser_done, 1'b0);
        check1("rst_busy", o_busy, 1'b0);
        check1("rst_full", o_fifo_full, 1'b0);
        check1("rst_empty", o_fifo_empty, 1'b1);
        i_rst_n = 1'b1;
        idle(2);

        // single packet
        step(1'b1, 64'hA5A5_0000_FFFF_1234);
        idle(110);

        // back-to-back
        for (int i = 0; i < 3; i++) step(1'b1, rnd64());
        idle(3 * SPAN + 20);

        // overflow while busy
        step(1'b1, rnd64());
        idle(5);
        for (int i = 0; i < 6; i++) step(1'b1, rnd64());
        checki("dropped_pushes", drops, 2);
        idle(5 * SPAN + 20);

        // push coinciding with the GAP-to-LOAD pop at count 1
        step(1'b1, rnd64());
        step(1'b1, rnd64());
        k = 0;
        while (cyc != last_pop + SPAN && k < 300) begin
            step(1'b0, '0);
            k++;
        end
        checki("pop_cycle_reached", cyc, last_pop + SPAN);
        checki("count_before_pushpop", mq.size(), 1);
        step(1'b1, rnd64());
        checki("count_after_pushpop", mq.size(), 1);
        idle(3 * SPAN + 20);

        // reset in the middle of a burst, at bit 20
        target = cyc + 3 + 20;
        step(1'b1, rnd64());
        k = 0;
        while (cyc < target && k < 100) begin
            step(1'b0, '0);
            k++;
        end
        i_rst_n = 1'b0;
        #1;
        check1("midrst_txdatasb", o_txdatasb, 1'b0);
        check1("midrst_txcksb_en", o_txcksb_en, 1'b0);
        check1("midrst_busy", o_busy, 1'b0);
        check1("midrst_empty", o_fifo_empty, 1'b1);
        mq.delete();
        sb.delete();
        has_pop = 1'b0;
        exp_pkts--;
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        step(1'b1, rnd64());
        idle(120);

        // alternating pattern twice
        step(1'b1, 64'hAAAA_AAAA_AAAA_AAAA);
        step(1'b1, 64'hAAAA_AAAA_AAAA_AAAA);
        idle(2 * SPAN + 20);

        // random traffic
        repeat (800) step($urandom_range(0, 7) == 0, rnd64());

        k = 0;
        while ((sb.size() > 0 || mq.size() > 0) && k < 1000) begin
            step(1'b0, '0);
            k++;
        end
        idle(5);
        checki("drain_scoreboard", sb.size(), 0);
        checki("drain_model_fifo", mq.size(), 0);
        checki("done_pulse_count", done_cnt, exp_pkts);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
